alu_issue: RTL and testbench
============================

# alu_issue

Decode-and-issue stage feeding the EX-stage ALU of the 5-cycle MIPS pipeline. It accepts one instruction per cycle from ID together with its register operand values, decodes it into the ALU's `op`/`mask`/`imm1`/`imm0` control word plus writeback info, and holds the result in the ID/EX pipeline register. A one-entry skid buffer provides valid/ready back-pressure with a registered `id_ready`.

## Interface
- `SKID`, default 1: skid buffer present (1) or bypassed with combinational `id_ready` (0).
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `id_valid` input 1: ID offers an instruction.
- `id_ready` output 1: stage can accept; registered when `SKID=1`.
- `id_instr` input 32: instruction word.
- `id_rs_val` / `id_rt_val` input 32 each: forwarded rs/rt values.
- `flush` input 1: discard all held entries (branch/exception).
- `ex_valid` output 1: control word valid.
- `ex_ready` input 1: EX consumes it.
- `ex_op` output 4: ALU op.
- `ex_mask` output 2: [1] a←imm1, [0] b←imm0.
- `ex_a` / `ex_b` output 32: rs/rt values.
- `ex_imm1` / `ex_imm0` output 32: immediate operands.
- `ex_wreg` output 5: destination register.
- `ex_wen` output 1: register write enable.
- `ex_illegal` output 1: held entry decoded as illegal.

## Operation
- ALU op encoding: 0 add, 1 sub, 2 sll(b<<a), 3 srl, 4 sra, 5 and, 6 or, 7 xor, 8 xnor, 9 sltu, 10 slt, 11 add-4.
- R-type (opcode 0), wreg=rd, wen=1, imm0=0:
  - funct 0x20/0x21 → op 0; 0x22/0x23 → 1; 0x24 → 5; 0x25 → 6; 0x26 → 7; 0x2A → 10; 0x2B → 9; all mask 00.
  - 0x00/0x02/0x03 → op 2/3/4, mask 10, imm1 = zero-extended shamt.
  - 0x04/0x06/0x07 → op 2/3/4, mask 00.
- I-type, wreg=rt, mask 01, imm1=0:
  - 0x08/0x09 → op 0, sext; 0x0A → 10, sext; 0x0B → 9, sext.
  - 0x0C/0x0D/0x0E → op 5/6/7, zext.
  - 0x0F lui → op 2, mask 11, imm1=16, imm0 = zext imm.
  - 0x23 lw → op 0, sext, wen=1.
  - 0x2B sw → op 0, sext, wen=0.
- Anything else is illegal: op 0, mask 00, wen=0, wreg=0, illegal=1.
- `rd`/`rt`=0 forces `ex_wen`=0.
- Storage: main register (drives `ex_*`) plus skid register.
- Accept when `id_valid && id_ready`:
  - Into main if main is empty or being consumed this cycle.
  - Otherwise into skid.
- On consume, skid moves to main.
- `id_ready` = skid empty (registered).

## Timing
- Reset: `ex_valid`=0, `id_ready`=1, `ex_illegal`=0, all `ex_*` data outputs 0; skid empty; FSM in RUN.
- Latency: accepted at edge N → `ex_valid` visible after edge N, stable until `ex_ready` is high at an edge.
- Full throughput with `ex_ready` held high: one issue per cycle, no bubbles.
- `ex_ready` low: first extra instruction lands in skid; `id_ready` drops the following cycle; no loss, no duplication.
- Simultaneous consume + accept with skid full is impossible (`id_ready`=0); with skid empty the new entry goes to main.
- `flush` dominates everything: main and skid cleared at the edge, `ex_valid`=0 next cycle, `id_ready`=1 next cycle, same-cycle `id_valid` dropped, FSM → RUN.
- Reset asserted mid-operation clears immediately and asynchronously, irrespective of clock.

## Configuration
- `ALU_ISSUE_ILLEGAL_TRAP_EN` defined:
  - FSM RUN/TRAP: issuing an illegal entry to main moves to TRAP.
  - TRAP: `id_ready`=0; the illegal entry stays presented with `ex_illegal`=1; later consumes do not clear it.
  - Only `flush` or reset returns to RUN.
- Undefined: no FSM; illegal entries flow through as NOPs with `ex_illegal`=1, and flow continues.

## Test plan
- Reset with `id_valid`=1 → `ex_valid`=0, `id_ready`=1, outputs 0 until `rst_n` rises.
- Stream `addiu $2,$1,-1` (0x2422FFFF), `sll $3,$2,4` (0x00021900), `lui $4,0x1234` (0x3C041234) with `ex_ready`=1 → consecutive cycles:
  - op0/mask01/imm0=0xFFFFFFFF/wreg2
  - op2/mask10/imm1=4/wreg3
  - op2/mask11/imm1=16/imm0=0x1234/wreg4
- Hold `ex_ready`=0 while offering 3 instructions → 2 accepted, `id_ready`=0 one cycle after the second; release → both emerge in order, third accepted.
- `flush` with main+skid full and `id_valid`=1 → `ex_valid`=0 next cycle, `id_ready`=1, nothing later emitted.
- `sw` 0xAC220004 → op0, mask01, imm0=4, wen=0; `addu $0,...` → wen=0.
- Illegal 0xFC000000 → `ex_illegal`=1, wen=0; with `ALU_ISSUE_ILLEGAL_TRAP_EN`, `id_ready` stays 0 until `flush`; without it, the next instruction issues normally.

Source files
------------

// File: rtl/alu_issue_if.sv
// ID -> issue -> EX handshake bundle for the ALU issue stage.
// master drives instructions and ex_ready; slave is the issue stage.
interface alu_issue_if;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_rs_val;
  logic [31:0] id_rt_val;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_op;
  logic [1:0]  ex_mask;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [31:0] ex_imm1;
  logic [31:0] ex_imm0;
  logic [4:0]  ex_wreg;
  logic        ex_wen;
  logic        ex_illegal;

  modport master (
    output id_valid, id_instr, id_rs_val, id_rt_val,
    output flush, ex_ready,
    input  id_ready, ex_valid, ex_op, ex_mask,
    input  ex_a, ex_b, ex_imm1, ex_imm0,
    input  ex_wreg, ex_wen, ex_illegal
  );

  modport slave (
    input  id_valid, id_instr, id_rs_val, id_rt_val,
    input  flush, ex_ready,
    output id_ready, ex_valid, ex_op, ex_mask,
    output ex_a, ex_b, ex_imm1, ex_imm0,
    output ex_wreg, ex_wen, ex_illegal
  );
endinterface

// File: rtl/alu_issue.sv
// MIPS decode/issue stage with a one-entry skid buffer into the EX ALU.
// Optional ALU_ISSUE_ILLEGAL_TRAP_EN: an illegal issue halts the stage until flush.
module alu_issue #(
  parameter int SKID = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  io
);

  typedef struct packed {
    logic [3:0]  op;
    logic [1:0]  mask;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm1;
    logic [31:0] imm0;
    logic [4:0]  wreg;
    logic        wen;
    logic        ill;
  } id_ex_t;

  function automatic id_ex_t decode(
    input logic [31:0] ins,
    input logic [31:0] rs_v,
    input logic [31:0] rt_v
  );
    id_ex_t      d;
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [31:0] sx;
    logic [31:0] zx;
    logic        ok;
    opc    = ins[31:26];
    fn     = ins[5:0];
    sx     = {{16{ins[15]}}, ins[15:0]};
    zx     = {16'h0, ins[15:0]};
    ok     = 1'b1;
    d      = '0;
    d.a    = rs_v;
    d.b    = rt_v;
    d.wen  = 1'b1;
    unique case (1'b1)
      (opc == 6'h00): begin
        d.wreg = ins[15:11];
        case (fn)
          6'h20, 6'h21: d.op = 4'd0;
          6'h22, 6'h23: d.op = 4'd1;
          6'h24:        d.op = 4'd5;
          6'h25:        d.op = 4'd6;
          6'h26:        d.op = 4'd7;
          6'h2A:        d.op = 4'd10;
          6'h2B:        d.op = 4'd9;
          6'h00, 6'h02, 6'h03: begin
            d.op   = (fn == 6'h00) ? 4'd2 :
                     (fn == 6'h02) ? 4'd3 : 4'd4;
            d.mask = 2'b10;
            d.imm1 = {27'h0, ins[10:6]};
          end
          6'h04:        d.op = 4'd2;
          6'h06:        d.op = 4'd3;
          6'h07:        d.op = 4'd4;
          default:      ok = 1'b0;
        endcase
      end
      default: begin
        d.wreg = ins[20:16];
        d.mask = 2'b01;
        case (opc)
          6'h08, 6'h09: d.imm0 = sx;
          6'h0A: begin d.op = 4'd10; d.imm0 = sx; end
          6'h0B: begin d.op = 4'd9;  d.imm0 = sx; end
          6'h0C: begin d.op = 4'd5;  d.imm0 = zx; end
          6'h0D: begin d.op = 4'd6;  d.imm0 = zx; end
          6'h0E: begin d.op = 4'd7;  d.imm0 = zx; end
          6'h0F: begin
            d.op   = 4'd2;
            d.mask = 2'b11;
            d.imm1 = 32'd16;
            d.imm0 = zx;
          end
          6'h23: d.imm0 = sx;
          6'h2B: begin d.imm0 = sx; d.wen = 1'b0; end
          default: ok = 1'b0;
        endcase
      end
    endcase
    if (!ok) begin
      d.op   = 4'd0;
      d.mask = 2'b00;
      d.imm1 = '0;
      d.imm0 = '0;
      d.wreg = '0;
      d.ill  = 1'b1;
    end
    if (d.wreg == 5'd0) d.wen = 1'b0;
    return d;
  endfunction

  id_ex_t main_q, skid_q, main_n, skid_n, dec;
  logic   main_v, skid_v, mv_n, sv_n;
  logic   rdy_q, rdy, acc, cons;
  logic   load_ill, trap, trap_go, trap_n;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
  typedef enum logic {RUN, TRAP} state_t;
  state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else if (io.flush) state <= RUN;
    else if (trap_go) state <= TRAP;
  end

  assign trap = (state == TRAP);
`else
  localparam bit TRAP_EN = 1'b0;
  assign trap = 1'b0;
`endif

  assign dec  = decode(io.id_instr, io.id_rs_val, io.id_rt_val);
  assign rdy  = (SKID != 0) ? rdy_q :
                (!trap && (!main_v || io.ex_ready));
  assign acc  = io.id_valid && rdy;
  assign cons = main_v && io.ex_ready && !trap;

  always_comb begin
    main_n = main_q;
    skid_n = skid_q;
    mv_n   = main_v;
    sv_n   = skid_v;
    if (cons) begin
      mv_n = skid_v || acc;
      sv_n = 1'b0;
      if (skid_v) main_n = skid_q;
      else if (acc) main_n = dec;
      if (skid_v && acc) begin
        skid_n = dec;
        sv_n   = 1'b1;
      end
    end else if (acc) begin
      if (!main_v) begin
        main_n = dec;
        mv_n   = 1'b1;
      end else begin
        skid_n = dec;
        sv_n   = 1'b1;
      end
    end
    // main is (re)loaded only on consume or accept into empty main
    load_ill = mv_n && main_n.ill &&
               (cons || (acc && !main_v));
    if (io.flush) begin
      mv_n = 1'b0;
      sv_n = 1'b0;
    end
  end

  assign trap_go = TRAP_EN && load_ill && !io.flush;
  assign trap_n  = !io.flush && (trap || trap_go);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
      main_v <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b1;
    end else begin
      main_q <= main_n;
      skid_q <= skid_n;
      main_v <= mv_n;
      skid_v <= sv_n;
      rdy_q  <= !sv_n && !trap_n;
    end
  end

  assign io.id_ready   = rdy;
  assign io.ex_valid   = main_v;
  assign io.ex_op      = main_q.op;
  assign io.ex_mask    = main_q.mask;
  assign io.ex_a       = main_q.a;
  assign io.ex_b       = main_q.b;
  assign io.ex_imm1    = main_q.imm1;
  assign io.ex_imm0    = main_q.imm0;
  assign io.ex_wreg    = main_q.wreg;
  assign io.ex_wen     = main_q.wen;
  assign io.ex_illegal = main_q.ill;

endmodule

// File: tb/tb_alu_issue.sv
// Directed-vector bench for alu_issue.
// Expected control words are hand-decoded from the MIPS encodings.
module tb_alu_issue;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  alu_issue_if bus ();

  alu_issue u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: sim exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] ins);
    bus.id_valid = 1'b1;
    bus.id_instr = ins;
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    bus.flush      = 1'b0;
    bus.ex_ready   = 1'b1;
    bus.id_rs_val  = 32'h0000_0011;
    bus.id_rt_val  = 32'h0000_0022;
    offer(32'h2422FFFF);
    repeat (3) step();
    chk("rst_valid", bus.ex_valid, 0);
    chk("rst_ready", bus.id_ready, 1);
    chk("rst_op", bus.ex_op, 0);
    chk("rst_imm0", bus.ex_imm0, 0);
    chk("rst_a", bus.ex_a, 0);
    chk("rst_ill", bus.ex_illegal, 0);
    bus.id_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("idle_valid", bus.ex_valid, 0);

    // streaming: addiu, sll, lui
    offer(32'h2422FFFF);
    step();
    chk("addiu_v", bus.ex_valid, 1);
    chk("addiu_op", bus.ex_op, 0);
    chk("addiu_mask", bus.ex_mask, 2'b01);
    chk("addiu_imm0", bus.ex_imm0, 32'hFFFFFFFF);
    chk("addiu_wreg", bus.ex_wreg, 2);
    chk("addiu_wen", bus.ex_wen, 1);
    chk("addiu_a", bus.ex_a, 32'h11);
    offer(32'h00021900);
    step();
    chk("sll_v", bus.ex_valid, 1);
    chk("sll_op", bus.ex_op, 2);
    chk("sll_mask", bus.ex_mask, 2'b10);
    chk("sll_imm1", bus.ex_imm1, 4);
    chk("sll_wreg", bus.ex_wreg, 3);
    offer(32'h3C041234);
    step();
    chk("lui_op", bus.ex_op, 2);
    chk("lui_mask", bus.ex_mask, 2'b11);
    chk("lui_imm1", bus.ex_imm1, 16);
    chk("lui_imm0", bus.ex_imm0, 32'h1234);
    chk("lui_wreg", bus.ex_wreg, 4);
    bus.id_valid = 1'b0;
    step();
    chk("drain_v", bus.ex_valid, 0);

    // back-pressure: add $3, sub $5, and $6
    bus.ex_ready = 1'b0;
    offer(32'h00221820);
    step();
    chk("bp_a_v", bus.ex_valid, 1);
    chk("bp_rdy1", bus.id_ready, 1);
    offer(32'h00222822);
    step();
    chk("bp_rdy0", bus.id_ready, 0);
    chk("bp_hold", bus.ex_wreg, 3);
    offer(32'h00223024);
    repeat (2) step();
    chk("bp_stall_wreg", bus.ex_wreg, 3);
    chk("bp_stall_op", bus.ex_op, 0);
    bus.ex_ready = 1'b1;
    step();
    chk("bp_b_wreg", bus.ex_wreg, 5);
    chk("bp_b_op", bus.ex_op, 1);
    chk("bp_rdy_back", bus.id_ready, 1);
    step();
    chk("bp_c_wreg", bus.ex_wreg, 6);
    chk("bp_c_op", bus.ex_op, 5);
    bus.id_valid = 1'b0;
    step();
    chk("bp_empty", bus.ex_valid, 0);

    // flush with main and skid occupied
    bus.ex_ready = 1'b0;
    offer(32'h00221820);
    step();
    offer(32'h00222822);
    step();
    chk("fl_full", bus.id_ready, 0);
    offer(32'h00223024);
    bus.flush = 1'b1;
    step();
    chk("fl_valid", bus.ex_valid, 0);
    chk("fl_ready", bus.id_ready, 1);
    bus.flush    = 1'b0;
    bus.id_valid = 1'b0;
    bus.ex_ready = 1'b1;
    repeat (2) step();
    chk("fl_quiet", bus.ex_valid, 0);

    // sw, addu to $0
    offer(32'hAC220004);
    step();
    chk("sw_op", bus.ex_op, 0);
    chk("sw_mask", bus.ex_mask, 2'b01);
    chk("sw_imm0", bus.ex_imm0, 4);
    chk("sw_wen", bus.ex_wen, 0);
    offer(32'h00220021);
    step();
    chk("r0_wen", bus.ex_wen, 0);
    chk("r0_mask", bus.ex_mask, 2'b00);

    // illegal opcode
    offer(32'hFC000000);
    step();
    chk("ill_v", bus.ex_valid, 1);
    chk("ill_flag", bus.ex_illegal, 1);
    chk("ill_wen", bus.ex_wen, 0);
    offer(32'h2422FFFF);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    chk("trap_rdy", bus.id_ready, 0);
    repeat (2) step();
    chk("trap_hold", bus.ex_illegal, 1);
    chk("trap_rdy2", bus.id_ready, 0);
    bus.id_valid = 1'b0;
    bus.flush    = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("trap_flush_v", bus.ex_valid, 0);
    chk("trap_flush_rdy", bus.id_ready, 1);
    offer(32'h2422FFFF);
`else
    chk("ill_rdy", bus.id_ready, 1);
`endif
    step();
    chk("post_ill", bus.ex_illegal, 0);
    chk("post_wreg", bus.ex_wreg, 2);
    chk("post_v", bus.ex_valid, 1);

    // asynchronous reset between edges
    bus.ex_ready = 1'b0;
    bus.id_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_v", bus.ex_valid, 0);
    chk("arst_wreg", bus.ex_wreg, 0);
    chk("arst_rdy", bus.id_ready, 1);
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
